// File: rtl/legv8_mem_responder.sv
// rtl/legv8_mem_responder.sv - wait-state memory responder on a shared tri-state data bus
// Little-endian 64-bit storage; sized, aligned accesses; faults reported in the response.
module legv8_mem_responder #(
  parameter int          ADDR_BITS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  inout  wire  [63:0] data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_WAIT    = 2'd1;
  localparam logic [1:0]  S_RESP    = 2'd2;
  localparam logic [32:0] SPAN      = 33'd8 << ADDR_BITS;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  logic [63:0]          mem_q [2**ADDR_BITS];
  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [2:0]           lane_q, lane_d;
  logic [1:0]           size_q, size_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;
  logic [63:0]          wdata_q, wdata_d;

  logic [32:0] offset;
  logic        in_range, req_any, req_both, misalign, write_en, drive;
  logic [63:0] wmask, wshift, rdata;

  function automatic logic [63:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Addresses below BASE_ADDR wrap and set the borrow bit, so one compare covers both bounds.
  assign offset   = {1'b0, address} - {1'b0, BASE_ADDR};
  assign in_range = !offset[32] && (offset < SPAN);
  assign req_any  = mem_read | mem_write;
  assign req_both = mem_read & mem_write;

  always_comb begin
    case (size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = address[0];
      2'd2:    misalign = |address[1:0];
      default: misalign = |address[2:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    wr_d    = wr_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (in_range && req_any) begin
          idx_d   = offset[ADDR_BITS+2:3];
          lane_d  = address[2:0];
          size_d  = size;
          wr_d    = mem_write & ~mem_read;
          err_d   = req_both | misalign;
          wdata_d = data;
          if (req_both || WAIT_INIT == 4'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!req_any) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (!req_any) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Commit exactly once, on the edge that enters RESP; reset suppresses a pending write.
  assign write_en = reset && (state_d == S_RESP) && (state_q != S_RESP) && wr_d && !err_d;
  assign wmask    = size_mask(size_d) << {lane_d, 3'b000};
  assign wshift   = wdata_d << {lane_d, 3'b000};

  always_ff @(posedge clock) begin
    if (write_en) mem_q[idx_d] <= (mem_q[idx_d] & ~wmask) | (wshift & wmask);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 3'd0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  assign rdata     = (mem_q[idx_q] >> {lane_q, 3'b000}) & size_mask(size_q);
  assign drive     = (state_q == S_RESP) && !wr_q && !err_q && mem_read;
  assign data      = drive ? rdata : {64{1'bz}};
  assign mem_ready = (state_q == S_RESP);
  assign mem_error = (state_q == S_RESP) && err_q;

endmodule
